// File: rtl/br_pkg.sv
// Shared definitions for the EX-stage branch resolution slice.
//   br_state_e : resolve FSM states (IDLE accepts work, REDIR holds a redirect)
//   INST_BYTES : fall-through increment between sequential instructions
package br_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      REDIR = 1'b1
   } br_state_e;

   localparam int unsigned INST_BYTES = 4;

endpackage : br_pkg

// File: rtl/br_outcome_cmp.sv
// Combinational outcome comparator.
// Works out the architecturally correct next PC of the instruction in EX and
// flags a mispredict when the PC that IF actually fetched next differs from it.
//   acc            in   1       instruction is being accepted this cycle
//   pc             in   ADDR_W  instruction address
//   br_inst        in   1       instruction is a branch/jump
//   actual_taken   in   1       real outcome
//   actual_target  in   ADDR_W  real target
//   pred_next_pc   in   ADDR_W  PC that IF fetched after this instruction
//   actual_next_c  out  ADDR_W  correct next PC
//   mispred_c      out  1       accepted instruction was followed by the wrong PC
module br_outcome_cmp
   import br_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              acc,
   input  logic [ADDR_W-1:0] pc,
   input  logic              br_inst,
   input  logic              actual_taken,
   input  logic [ADDR_W-1:0] actual_target,
   input  logic [ADDR_W-1:0] pred_next_pc,
   output logic [ADDR_W-1:0] actual_next_c,
   output logic              mispred_c
);

   logic [ADDR_W-1:0] seq_pc;
   logic              taken_eff;

   // Fall-through address; the add is ADDR_W wide so it wraps at the top of memory.
   assign seq_pc = pc + ADDR_W'(INST_BYTES);

   // A non-branch never redirects, whatever the outcome input says.
   assign taken_eff = br_inst & actual_taken;

   // Select correct next PC.
   always_comb begin
      actual_next_c = seq_pc;
      if (taken_eff) begin
         actual_next_c = actual_target;
      end
   end

   // Comparing full next PCs (not just direction) also catches a non-branch
   // that IF steered elsewhere through a BTB alias, and a taken branch whose
   // predicted target was stale.
   assign mispred_c = acc & (pred_next_pc != actual_next_c);

endmodule : br_outcome_cmp

// File: rtl/br_resolve_unit.sv
// EX-stage branch resolution unit.
// Checks the fetch-time prediction against the real outcome, raises a one-cycle
// flush and holds a redirect to IF on a mispredict, drives the predictor update
// port one cycle after each resolved branch, and counts resolved branches and
// redirects.
//   clk, reset           clock; synchronous active-high reset
//   ex_valid/ex_ready    EX handshake; ready only while no redirect is pending
//   ex_pc .. ex_actual_* instruction, prediction and real outcome from EX
//   flush                one-cycle pulse killing younger instructions
//   redir_valid/_pc/_ready  redirect handshake towards IF
//   upd_*                registered predictor update (upd_en = strobe)
//   resolved_count       branches resolved
//   mispred_count        redirects issued
module br_resolve_unit #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [ADDR_W-1:0] ex_pc,
   input  logic              ex_br_inst,
   input  logic              ex_cond_br_inst,
   input  logic              ex_pred_taken,
   input  logic [ADDR_W-1:0] ex_pred_next_pc,
   input  logic              ex_actual_taken,
   input  logic [ADDR_W-1:0] ex_actual_target,

   output logic              flush,
   output logic              redir_valid,
   output logic [ADDR_W-1:0] redir_pc,
   input  logic              redir_ready,

   output logic              upd_en,
   output logic [ADDR_W-1:0] upd_inst_addr,
   output logic              upd_br_inst,
   output logic              upd_cond_br_inst,
   output logic              upd_br_taken,
   output logic [ADDR_W-1:0] upd_br_target,

   output logic [CNT_W-1:0]  resolved_count,
   output logic [CNT_W-1:0]  mispred_count
);

   import br_pkg::*;

   br_state_e         state_q;
   br_state_e         state_d;

   logic              acc_c;
   logic              mispred_c;
   logic              redir_done_c;
   logic [ADDR_W-1:0] actual_next_c;

   // The direction bit is subsumed by the next-PC comparison; kept on the
   // port for pipeline tracing only.
   logic              unused_pred_taken;
   assign unused_pred_taken = ex_pred_taken;

   assign acc_c        = ex_valid & ex_ready;
   assign redir_done_c = redir_valid & redir_ready;

   // Outcome comparison.
   br_outcome_cmp #(
      .ADDR_W (ADDR_W)
   ) u_outcome_cmp (
      .acc           (acc_c),
      .pc            (ex_pc),
      .br_inst       (ex_br_inst),
      .actual_taken  (ex_actual_taken),
      .actual_target (ex_actual_target),
      .pred_next_pc  (ex_pred_next_pc),
      .actual_next_c (actual_next_c),
      .mispred_c     (mispred_c)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (mispred_c) begin
               state_d = REDIR;
            end
         end
         REDIR: begin
            if (redir_done_c) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM outputs: EX is stalled for the whole redirect so wrong-path
   // instructions never reach the comparator or the predictor.
   always_comb begin
      ex_ready = 1'b0;
      case (state_q)
         IDLE:    ex_ready = 1'b1;
         REDIR:   ex_ready = 1'b0;
         default: ex_ready = 1'b0;
      endcase
   end

   // Flush pulse and redirect request; redir_pc only loads on a new
   // mispredict, which cannot occur while one is pending, so it stays stable.
   always_ff @(posedge clk) begin
      if (reset) begin
         flush       <= 1'b0;
         redir_valid <= 1'b0;
         redir_pc    <= '0;
      end else begin
         flush <= mispred_c;
         if (mispred_c) begin
            redir_valid <= 1'b1;
            redir_pc    <= actual_next_c;
         end else if (redir_done_c) begin
            redir_valid <= 1'b0;
         end
      end
   end

   // Predictor update port: strobe only for accepted branches, payload
   // captured on every accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         upd_en           <= 1'b0;
         upd_inst_addr    <= '0;
         upd_br_inst      <= 1'b0;
         upd_cond_br_inst <= 1'b0;
         upd_br_taken     <= 1'b0;
         upd_br_target    <= '0;
      end else begin
         upd_en <= acc_c & ex_br_inst;
         if (acc_c) begin
            upd_inst_addr    <= ex_pc;
            upd_br_inst      <= ex_br_inst;
            upd_cond_br_inst <= ex_cond_br_inst;
            upd_br_taken     <= ex_br_inst & ex_actual_taken;
            upd_br_target    <= ex_actual_target;
         end
      end
   end

   // Statistics counters, free-running modulo 2^CNT_W.
   always_ff @(posedge clk) begin
      if (reset) begin
         resolved_count <= '0;
         mispred_count  <= '0;
      end else begin
         if (acc_c && ex_br_inst) begin
            resolved_count <= resolved_count + CNT_W'(1);
         end
         if (mispred_c) begin
            mispred_count <= mispred_count + CNT_W'(1);
         end
      end
   end

endmodule : br_resolve_unit

// File: tb/tb_br_resolve_unit.sv
// Self-checking bench for br_resolve_unit: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_br_resolve_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_pc;
   logic        ex_br_inst;
   logic        ex_cond_br_inst;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_next_pc;
   logic        ex_actual_taken;
   logic [31:0] ex_actual_target;
   logic        flush;
   logic        redir_valid;
   logic [31:0] redir_pc;
   logic        redir_ready;
   logic        upd_en;
   logic [31:0] upd_inst_addr;
   logic        upd_br_inst;
   logic        upd_cond_br_inst;
   logic        upd_br_taken;
   logic [31:0] upd_br_target;
   logic [31:0] resolved_count;
   logic [31:0] mispred_count;

   br_resolve_unit #(.ADDR_W(32), .CNT_W(32)) dut (
      .clk              (clk),
      .reset            (reset),
      .ex_valid         (ex_valid),
      .ex_ready         (ex_ready),
      .ex_pc            (ex_pc),
      .ex_br_inst       (ex_br_inst),
      .ex_cond_br_inst  (ex_cond_br_inst),
      .ex_pred_taken    (ex_pred_taken),
      .ex_pred_next_pc  (ex_pred_next_pc),
      .ex_actual_taken  (ex_actual_taken),
      .ex_actual_target (ex_actual_target),
      .flush            (flush),
      .redir_valid      (redir_valid),
      .redir_pc         (redir_pc),
      .redir_ready      (redir_ready),
      .upd_en           (upd_en),
      .upd_inst_addr    (upd_inst_addr),
      .upd_br_inst      (upd_br_inst),
      .upd_cond_br_inst (upd_cond_br_inst),
      .upd_br_taken     (upd_br_taken),
      .upd_br_target    (upd_br_target),
      .resolved_count   (resolved_count),
      .mispred_count    (mispred_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: a pending redirect (or none) plus the expected
   // observations after the next edge.
   bit          m_pending = 1'b0;
   logic [31:0] m_redir_pc = '0;
   logic [31:0] m_resolved = '0;
   logic [31:0] m_mispred = '0;
   bit          m_flush = 1'b0;
   bit          m_upd = 1'b0;
   logic [31:0] m_upd_pc, m_upd_tgt;
   bit          m_upd_cond, m_upd_taken;
   bit          m_reset_seen = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] next_pc_of(input logic [31:0] pc, input bit br,
                                               input bit taken, input logic [31:0] tgt);
      return (br && taken) ? tgt : pc + 32'd4;
   endfunction

   task automatic drive(input bit v, input logic [31:0] pc, input bit br, input bit cond,
                        input bit ptaken, input logic [31:0] pnext, input bit taken,
                        input logic [31:0] tgt);
      ex_valid = v; ex_pc = pc; ex_br_inst = br; ex_cond_br_inst = cond;
      ex_pred_taken = ptaken; ex_pred_next_pc = pnext;
      ex_actual_taken = taken; ex_actual_target = tgt;
   endtask

   // One clock: predict from the inputs of this cycle, advance, compare.
   task automatic tick();
      bit          accepted, wrong;
      logic [31:0] nxt;
      chk("ex_ready_pre", ex_ready, !m_pending || m_reset_seen == 1'b0 ? 1'b1 : 1'b0);
      accepted = ex_valid && !m_pending;
      nxt      = next_pc_of(ex_pc, ex_br_inst, ex_actual_taken, ex_actual_target);
      wrong    = accepted && (ex_pred_next_pc != nxt);
      if (reset) begin
         m_pending = 0; m_redir_pc = '0; m_resolved = '0; m_mispred = '0;
         m_flush = 0; m_upd = 0;
      end else begin
         m_flush = wrong;
         m_upd   = accepted && ex_br_inst;
         if (m_upd) begin
            m_upd_pc = ex_pc; m_upd_cond = ex_cond_br_inst;
            m_upd_taken = ex_actual_taken; m_upd_tgt = ex_actual_target;
            m_resolved++;
         end
         if (m_pending && redir_ready) m_pending = 0;
         if (wrong) begin
            m_pending = 1; m_redir_pc = nxt; m_mispred++;
         end
      end
      @(posedge clk);
      #1;
      m_reset_seen = 1'b1;
      chk("flush", flush, m_flush);
      chk("upd_en", upd_en, m_upd);
      chk("ex_ready", ex_ready, !m_pending);
      chk("redir_valid", redir_valid, m_pending);
      if (m_pending) chk("redir_pc", redir_pc, m_redir_pc);
      chk("resolved_count", resolved_count, m_resolved);
      chk("mispred_count", mispred_count, m_mispred);
      if (m_upd) begin
         chk("upd_inst_addr", upd_inst_addr, m_upd_pc);
         chk("upd_br_inst", upd_br_inst, 1'b1);
         chk("upd_cond_br_inst", upd_cond_br_inst, m_upd_cond);
         chk("upd_br_taken", upd_br_taken, m_upd_taken);
         chk("upd_br_target", upd_br_target, m_upd_tgt);
      end
      if (reset) begin
         chk("rst_redir_pc", redir_pc, 32'h0);
         chk("rst_upd_addr", upd_inst_addr, 32'h0);
         chk("rst_upd_tgt", upd_br_target, 32'h0);
         chk("rst_upd_bits", {upd_br_inst, upd_cond_br_inst, upd_br_taken}, 3'b000);
      end
   endtask

   initial begin
      reset = 1'b1;
      redir_ready = 1'b0;
      drive(0, '0, 0, 0, 0, '0, 0, '0);
      tick();
      tick();
      reset = 1'b0;

      // Correctly predicted taken beq.
      drive(1, 32'h1000, 1, 1, 1, 32'h1040, 1, 32'h1040);
      tick();
      chk("beq_upd_en", upd_en, 1'b1);
      chk("beq_taken", upd_br_taken, 1'b1);
      chk("beq_target", upd_br_target, 32'h1040);
      chk("beq_flush", flush, 1'b0);
      chk("beq_resolved", resolved_count, 32'd1);
      chk("beq_mispred", mispred_count, 32'd0);

      // Predicted not-taken, actually taken, with redirect backpressure.
      drive(1, 32'h2000, 1, 1, 0, 32'h2004, 1, 32'h1F00);
      tick();
      chk("mp_flush", flush, 1'b1);
      chk("mp_redir_pc", redir_pc, 32'h1F00);
      drive(1, 32'h5555_0000, 1, 1, 0, 32'h0, 1, 32'h1234);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_valid", redir_valid, 1'b1);
         chk("bp_pc", redir_pc, 32'h1F00);
         chk("bp_ex_ready", ex_ready, 1'b0);
         chk("bp_flush", flush, 1'b0);
      end
      redir_ready = 1'b1;
      drive(0, '0, 0, 0, 0, '0, 0, '0);
      tick();
      chk("bp_idle_valid", redir_valid, 1'b0);
      chk("bp_idle_ready", ex_ready, 1'b1);
      chk("bp_resolved", resolved_count, 32'd2);

      // Non-branch predicted taken through a BTB alias; ready already high.
      drive(1, 32'h3000, 0, 0, 1, 32'h3100, 0, 32'h3100);
      tick();
      chk("nb_flush", flush, 1'b1);
      chk("nb_redir_pc", redir_pc, 32'h3004);
      chk("nb_upd_en", upd_en, 1'b0);
      chk("nb_mispred", mispred_count, 32'd2);
      drive(0, '0, 0, 0, 0, '0, 0, '0);
      tick();
      chk("nb_valid_fall", redir_valid, 1'b0);
      chk("nb_ready_rise", ex_ready, 1'b1);

      // Reset while a redirect is pending.
      redir_ready = 1'b0;
      drive(1, 32'h4000, 1, 1, 0, 32'h4004, 1, 32'h4800);
      tick();
      drive(0, '0, 0, 0, 0, '0, 0, '0);
      reset = 1'b1;
      tick();
      chk("rr_valid", redir_valid, 1'b0);
      chk("rr_flush", flush, 1'b0);
      chk("rr_counts", {resolved_count, mispred_count}, 64'h0);
      chk("rr_ready", ex_ready, 1'b1);
      reset = 1'b0;
      tick();
      chk("rr_no_flush", flush, 1'b0);

      // Fall-through wraps past the top of the address space.
      drive(1, 32'hFFFF_FFFC, 1, 1, 0, 32'h0, 0, 32'h0000_8000);
      tick();
      chk("wrap_flush", flush, 1'b0);
      chk("wrap_mispred", mispred_count, 32'd0);
      chk("wrap_upd_en", upd_en, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] pc, tgt, pn;
         bit          br, taken;
         pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
         tgt   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
         if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
         br    = ($urandom_range(0, 3) != 0);
         taken = $urandom_range(0, 1);
         case ($urandom_range(0, 7))
            0:       pn = pc + 32'd4;
            1:       pn = tgt;
            2:       pn = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            default: pn = next_pc_of(pc, br, taken, tgt);
         endcase
         drive($urandom_range(0, 4) != 0, pc, br, br & $urandom_range(0, 1),
               $urandom_range(0, 1), pn, taken, tgt);
         redir_ready = $urandom_range(0, 1);
         reset = ($urandom_range(0, 99) == 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_br_resolve_unit
